// File: rtl/dff_pipe.sv
// dff_pipe: bubble-collapsing valid/ready register pipeline; define DFF_PIPE_STATS_EN to add the stall_cnt output
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rs_n,
  input  logic sclr,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DFF_PIPE_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] v, v_nxt, load, pv;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] pd [DEPTH];
  logic [CW-1:0] cnt_nxt;
  logic acc;
  // a stage loads when it or any stage ahead of it is empty, or the output drains
  always_comb begin
    acc = out_ready;
    load = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc = acc || !v[i];
      load[i] = acc;
    end
    pv = DEPTH'({v, in_valid});
    pd[0] = in_data;
    for (int i = 1; i < DEPTH; i++) pd[i] = d[i-1];
    v_nxt = sclr ? '0 : (load & pv) | (~load & v);
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(v_nxt[i]);
  end
  assign in_ready = rs_n && load[0] && !sclr;
  assign out_valid = v[DEPTH-1];
  assign out_data = d[DEPTH-1];
  // stage registers: sclr reloads RST_VAL, otherwise each loading stage takes its predecessor
  always_ff @(posedge clk or negedge rs_n)
    if (!rs_n) begin
      v <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= RST_VAL;
    end else begin
      v <= v_nxt;
      count <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++) d[i] <= sclr ? RST_VAL : load[i] ? pd[i] : d[i];
    end
`ifdef DFF_PIPE_STATS_EN
  // saturating count of cycles where the output beat is held back by downstream
  always_ff @(posedge clk or negedge rs_n)
    if (!rs_n) stall_cnt <= '0;
    else if (sclr) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed and random checks of dff_pipe (DEPTH=4 and DEPTH=1) against a beat-position model
module tb_dff_pipe;
  localparam int D = 4;
  localparam logic [7:0] RV = 8'h5A;
  logic clk = 0;
  logic rs_n = 0, sclr = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, in_ready1, out_valid1;
  logic [7:0] out_data, out_data1;
  logic [2:0] count;
  logic [0:0] count1;
`ifdef DFF_PIPE_STATS_EN
  logic [15:0] stall_cnt, stall_cnt1;
`endif
  int checks = 0, fails = 0, stall_exp = 0;
  int qpos[$];
  logic [7:0] qdat[$];
  logic [7:0] q1[$];

  dff_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(RV)) u_dut (
    .clk(clk), .rs_n(rs_n), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
`ifdef DFF_PIPE_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV)) u_d1 (
    .clk(clk), .rs_n(rs_n), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count(count1)
`ifdef DFF_PIPE_STATS_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: apply inputs, compare against the model, then advance the model across the edge
  task automatic cycle(input bit iv, input logic [7:0] id, input bit ordy, input bit sc);
    int np[$];
    int prev, p;
    bit ov, pop, rdy, rdy1;
    in_valid = iv; in_data = id; out_ready = ordy; sclr = sc;
    #1;
    ov = qpos.size() > 0 && qpos[0] == D - 1;
    chk("out_valid", out_valid, ov);
    chk("count", count, qpos.size());
    if (ov) chk("out_data", out_data, qdat[0]);
    pop = ov && ordy;
    prev = D;
    for (int k = pop ? 1 : 0; k < qpos.size(); k++) begin
      p = (qpos[k] + 1 < prev - 1) ? qpos[k] + 1 : prev - 1;
      np.push_back(p);
      prev = p;
    end
    rdy = !sc && (np.size() == 0 ? 1'b1 : np[$] > 0);
    chk("in_ready", in_ready, rdy);
    rdy1 = !sc && (q1.size() == 0 || ordy);
    chk("d1_out_valid", out_valid1, q1.size() > 0);
    chk("d1_count", count1, q1.size());
    if (q1.size() > 0) chk("d1_out_data", out_data1, q1[0]);
    chk("d1_in_ready", in_ready1, rdy1);
`ifdef DFF_PIPE_STATS_EN
    chk("stall_cnt", stall_cnt, stall_exp);
`endif
    @(posedge clk);
    if (sc) begin
      qpos.delete(); qdat.delete(); q1.delete(); stall_exp = 0;
    end else begin
      if (ov && !ordy && stall_exp != 65535) stall_exp++;
      if (pop) void'(qdat.pop_front());
      qpos = np;
      if (iv && rdy) begin qpos.push_back(0); qdat.push_back(id); end
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (iv && rdy1) q1.push_back(id);
    end
    @(negedge clk);
  endtask

  // pulse rs_n low between edges; everything must clear without a clock
  task automatic pulse_reset();
    in_valid = 0; sclr = 0;
    #1 rs_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, RV);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_d1_out_valid", out_valid1, 0);
    chk("rst_d1_out_data", out_data1, RV);
`ifdef DFF_PIPE_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    qpos.delete(); qdat.delete(); q1.delete(); stall_exp = 0;
    #1 rs_n = 1;
    #1;
    chk("rdy_after_rst", in_ready, 1);
    chk("d1_rdy_after_rst", in_ready1, 1);
    @(negedge clk);
  endtask

  initial begin
    int pct;
    @(negedge clk);
    pulse_reset();
    // streaming with no stalls: latency DEPTH, and 1 for the single-entry slice
    for (int i = 1; i <= 8; i++) begin
      if (i >= 5) chk("lat4", out_data, i - 4);
      if (i >= 2) chk("lat1", out_data1, i - 1);
      cycle(1, 8'(i), 1, 0);
    end
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0);
    // fill while stalled, then full-throughput accept
    for (int i = 0; i < 4; i++) cycle(1, 8'hA1 + 8'(i), 0, 0);
    chk("full_count", count, 4);
    chk("full_data", out_data, 8'hA1);
    in_valid = 1; in_data = 8'hA5; out_ready = 0;
    #1 chk("full_not_ready", in_ready, 0);
    cycle(1, 8'hA5, 0, 0);
    chk("stall_stable", out_data, 8'hA1);
    in_valid = 1; in_data = 8'hA5; out_ready = 1;
    #1 chk("full_thru_ready", in_ready, 1);
    cycle(1, 8'hA5, 1, 0);
    for (int j = 0; j < 4; j++) begin
      chk("drain_order", out_data, 8'hA2 + 8'(j));
      cycle(0, 8'h00, 1, 0);
    end
    for (int i = 0; i < 2; i++) cycle(0, 8'h00, 1, 0);
    // bubbles collapse behind a stalled output
    cycle(1, 8'h10, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h20, 0, 0);
    cycle(0, 8'h00, 0, 0);
    chk("bubble_count", count, 2);
    chk("bubble_data", out_data, 8'h10);
    cycle(1, 8'h30, 0, 0);
    chk("three_held", count, 3);
    // synchronous clear overrides an offered beat
    in_valid = 1; in_data = 8'h77; out_ready = 0; sclr = 1;
    #1 chk("sclr_not_ready", in_ready, 0);
    cycle(1, 8'h77, 0, 1);
    chk("sclr_count", count, 0);
    chk("sclr_out_valid", out_valid, 0);
    chk("sclr_out_data", out_data, RV);
    chk("sclr_d1_out_data", out_data1, RV);
    // stall counting: one beat held for five visible cycles
    cycle(1, 8'h44, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 0, 0);
`ifdef DFF_PIPE_STATS_EN
    chk("stall_five", stall_cnt, 5);
`endif
    for (int i = 0; i < 2; i++) cycle(0, 8'h00, 1, 0);
    // asynchronous reset with two beats held
    cycle(1, 8'hB1, 0, 0);
    cycle(1, 8'hB2, 0, 0);
    chk("held_two", count, 2);
    pulse_reset();
    // randomized traffic with alternating back-pressure levels
    for (int n = 0; n < 600; n++) begin
      pct = ((n / 100) % 2 == 1) ? 30 : 85;
      if (n % 200 == 199) pulse_reset();
      else cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) < pct,
                 $urandom_range(0, 49) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets the data bit width; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, sets the number of register stages; legal range 1..16.
REQ-003 Parameter RST_VAL, default 0, WIDTH bits, is the value loaded into every data stage on reset and on sclr.
REQ-004 Port clk  input  1  is the single clock; all state changes occur on its rising edge except reset.
REQ-005 Port rs_n  input  1  is the asynchronous, active-low reset.
REQ-006 Port sclr  input  1  is the synchronous clear of the whole pipeline.
REQ-007 Port in_valid  input  1  means the upstream beat is valid.
REQ-008 Port in_ready  output  1  means dff_pipe accepts the beat this cycle.
REQ-009 Port in_data  input  WIDTH  is the upstream beat payload.
REQ-010 Port out_valid  output  1  means the last stage holds a valid beat.
REQ-011 Port out_ready  input  1  means downstream accepts the beat this cycle.
REQ-012 Port out_data  output  WIDTH  is the last-stage payload.
REQ-013 Port count  output  $clog2(DEPTH+1)  is the number of valid stages, 0..DEPTH.

Function
REQ-014 Each stage i (0 = input side, DEPTH-1 = output side) SHALL hold one data register and one valid bit.
REQ-015 Stage i SHALL load from stage i-1 (stage 0 from in_data/in_valid) when stage i is empty or stage i's content advances this cycle.
REQ-016 Stage DEPTH-1 advances when out_valid=1 and out_ready=1; stage i<DEPTH-1 advances when stage i+1 loads.
REQ-017 Bubbles SHALL collapse: an empty stage SHALL accept data even while downstream stages are stalled.
REQ-018 in_ready SHALL equal (stage 0 empty OR stage 0 advances) AND NOT sclr; this is a combinational ripple from out_ready.
REQ-019 A beat is transferred in only when in_valid=1 and in_ready=1 in the same cycle; otherwise stage 0 valid is cleared on load.
REQ-020 With no stalls, a beat accepted in cycle t SHALL appear on out_data with out_valid=1 in cycle t+DEPTH.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-022 Beat order SHALL be preserved; no beat is duplicated or dropped.
REQ-023 When full (count=DEPTH) and out_ready=1, a new beat SHALL be accepted in the same cycle (full throughput, 1 beat/cycle).
REQ-024 sclr=1 SHALL clear all valid bits and load RST_VAL into all data stages at the next edge, overriding any transfer; the beat at out_data that cycle is discarded.
REQ-025 count SHALL be the registered popcount of valid bits, updated each edge.
REQ-026 DEPTH=1 SHALL behave as a single-entry register slice with in_ready = !out_valid || out_ready.

Reset
REQ-027 rs_n=0 SHALL immediately, without a clock, clear all valid bits, load RST_VAL into all data stages, and drive out_valid=0, out_data=RST_VAL, count=0.
REQ-028 in_ready SHALL be 0 while rs_n=0 and 1 in the first cycle after rs_n deasserts (pipeline empty).
REQ-029 Reset asserted mid-stream SHALL discard all held beats.

Configuration
REQ-030 With macro DFF_PIPE_STATS_EN defined, an output stall_cnt [15:0] SHALL count cycles with out_valid=1 and out_ready=0, saturating at 16'hFFFF, cleared by rs_n=0 and sclr=1.
REQ-031 Without DFF_PIPE_STATS_EN, the stall_cnt port and its logic SHALL not exist; all other behaviour is identical.

Verification
REQ-032 WIDTH=8, DEPTH=4, out_ready=1, inputs 8'h01..8'h08 on consecutive cycles -> outputs 8'h01..8'h08 each 4 cycles after acceptance, in_ready always 1.
REQ-033 Fill with 8'hA1..8'hA4, out_ready=0 -> count=4, in_ready=0, out_data=8'hA1 stable; then out_ready=1 with in_data=8'hA5 -> A5 accepted same cycle, outputs A1..A5 in order.
REQ-034 Gaps: beats 8'h10, idle, 8'h20 with out_ready=0 -> bubbles collapse, count=2 after 4 cycles, out_data=8'h10.
REQ-035 Pipeline holding 3 beats, sclr=1 for one cycle with in_valid=1 -> count=0, out_valid=0, out_data=RST_VAL, that input beat not accepted.
REQ-036 rs_n pulsed low between clock edges with 2 beats held -> out_valid=0 and count=0 immediately, in_ready=1 in the first cycle after release.
REQ-037 DFF_PIPE_STATS_EN defined, out_valid=1 held with out_ready=0 for 5 cycles -> stall_cnt=5; DEPTH=1 run of REQ-032 stimulus -> 1-cycle latency, full throughput.
